mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
Memory-access stage of the 16-bit pipeline, fed directly by the EX/MEM register outputs. Contains a word-addressed data memory with configurable access latency. Resolves branches (pc_src and branch_target back to fetch) and drives mem_stall upstream while a multi-cycle access is in progress. Registers write-back values into the MEM/WB boundary for the register-file write port.

Parameters:
ADDR_W, 8, word-address width; memory depth is 2**ADDR_W words of 16 bits.
MEM_LATENCY, 1, cycles per load or store; legal range 1..15.

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  synchronous active-high reset
alu_result_in  input  16  memory word address, or ALU result passed to WB
zero_in  input  1  ALU zero flag
adder_result_in  input  16  branch target
read_data_2_in  input  16  store data
mux_rd_rt_in  input  3  destination register index
MemToReg_in  input  1  WB source select
RegWrite_in  input  1  register write enable
MemRead_in  input  1  load request
MemWrite_in  input  1  store request
Branch_in  input  1  branch instruction
pc_src  output  1  combinational: Branch_in & zero_in
branch_target  output  16  combinational: adder_result_in
mem_stall  output  1  combinational: upstream must hold its inputs
read_data_out  output  16  registered load data
alu_result_out  output  16  registered alu_result_in
mux_rd_rt_out  output  3  registered destination index
MemToReg_out  output  1  registered
RegWrite_out  output  1  registered
addr_fault_out  output  1  registered address fault; tied 0 unless MEM_RANGE_CHECK_EN

Behaviour:
- access = MemRead_in | MemWrite_in. Word address = alu_result_in[ADDR_W-1:0]; upper bits are ignored unless MEM_RANGE_CHECK_EN is defined.
- FSM states: IDLE and BUSY. A 4-bit counter cnt tracks remaining wait cycles.
- IDLE, no access: every posedge loads the WB registers from the inputs (read_data_out <= 0).
- IDLE, access, MEM_LATENCY==1: the access completes on that edge; mem_stall stays 0.
- IDLE, access, MEM_LATENCY>1: mem_stall = 1. On the next edge: state <= BUSY, cnt <= MEM_LATENCY-2, WB registers load a bubble (RegWrite_out=0, MemToReg_out=0, others 0).
- BUSY: mem_stall = (cnt != 0).
  - cnt != 0: cnt decrements and a bubble is loaded.
  - cnt == 0: the access completes on that edge and state <= IDLE.
- Completion edge:
  - Store: mem[addr] <= read_data_2_in.
  - Load: read_data_out <= mem[addr] (read-before-write).
  - All other WB registers load from the inputs.
- Total access latency is MEM_LATENCY cycles. mem_stall is high for the first MEM_LATENCY-1 of them. The memory is written exactly once per store.
- MemRead_in and MemWrite_in both high: the write is performed and read_data_out returns the pre-write contents.
- Inputs must be held stable by upstream while mem_stall=1. No behaviour is defined if they change.
- pc_src and branch_target are independent of FSM state. Branch and memory access never coincide.
- Reset:
  - state IDLE, cnt 0, all registered outputs 0, mem_stall 0 from the cycle after reset.
  - Memory contents are not cleared.
  - Reset during BUSY abandons the access; a pending store is never written.
  - rst has priority over completion on the same edge.

Optional Feature:
MEM_RANGE_CHECK_EN
- Defined: an access with any nonzero bit in alu_result_in[15:ADDR_W] is out of range.
  - Its store is suppressed and its load returns 0.
  - addr_fault_out=1 is registered with that access's WB values (one-cycle pulse).
  - Latency and stall timing are unchanged.
- Not defined: addr_fault_out is constant 0 and upper address bits are ignored (aliasing).

Test Plan:
1. Reset: assert rst one edge with random inputs -> all registered outputs 0, mem_stall 0, next edge.
2. MEM_LATENCY=1: store 0xBEEF at addr 5, then load addr 5 with rd=3, MemToReg=1, RegWrite=1 -> read_data_out=0xBEEF, mux_rd_rt_out=3, RegWrite_out=1 one edge after the load; mem_stall never 1.
3. MEM_LATENCY=3: load addr 5 -> mem_stall=1 for exactly 2 cycles, 2 bubble WB cycles (RegWrite_out=0), then read_data_out=0xBEEF on the 3rd edge, mem_stall=0.
4. Branch: Branch_in=1, zero_in=1, adder_result_in=0x0040 -> pc_src=1, branch_target=0x0040 same cycle; zero_in=0 -> pc_src=0.
5. MEM_LATENCY=3: store 0x1234 to addr 7 (previously 0x0000), rst on 2nd cycle -> mem[7] still 0x0000, mem_stall=0 after reset.
6. ADDR_W=8: store 0xAAAA to 0x0105 -> with MEM_RANGE_CHECK_EN: mem[5] unchanged, addr_fault_out=1 for one cycle; without the macro: mem[5]=0xAAAA, addr_fault_out=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM stage of the 16-bit pipeline: data memory, branch resolve, MEM/WB regs.
// Optional MEM_RANGE_CHECK_EN flags accesses beyond the 2**ADDR_W word window.
module mem_wb_stage #(
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] alu_result_in,
  input  logic        zero_in,
  input  logic [15:0] adder_result_in,
  input  logic [15:0] read_data_2_in,
  input  logic [2:0]  mux_rd_rt_in,
  input  logic        MemToReg_in,
  input  logic        RegWrite_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        Branch_in,
  output logic        pc_src,
  output logic [15:0] branch_target,
  output logic        mem_stall,
  output logic [15:0] read_data_out,
  output logic [15:0] alu_result_out,
  output logic [2:0]  mux_rd_rt_out,
  output logic        MemToReg_out,
  output logic        RegWrite_out,
  output logic        addr_fault_out
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic MULTI = (MEM_LATENCY > 1);
  localparam logic [3:0] CNT_INIT =
    (MEM_LATENCY > 1) ? 4'(MEM_LATENCY - 2) : 4'd0;

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic access, fault, complete, bubble;
  logic [ADDR_W-1:0] addr;
  logic [15:0] mem [2**ADDR_W];

  assign access        = MemRead_in | MemWrite_in;
  assign addr          = alu_result_in[ADDR_W-1:0];
  assign pc_src        = Branch_in & zero_in;
  assign branch_target = adder_result_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (access && MULTI) begin
          state_n = BUSY;
          cnt_n   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) cnt_n = cnt - 4'd1;
        else state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_stall = 1'b0;
    complete  = 1'b0;
    bubble    = 1'b0;
    unique case (state)
      IDLE: begin
        mem_stall = access & MULTI;
        bubble    = access & MULTI;
        complete  = access & ~MULTI;
      end
      BUSY: begin
        mem_stall = (cnt != 4'd0);
        bubble    = (cnt != 4'd0);
        complete  = (cnt == 4'd0);
      end
    endcase
  end

  // Gating on rst drops a store whose completion edge coincides with reset.
  always_ff @(posedge clk) begin
    if (!rst && complete && MemWrite_in && !fault)
      mem[addr] <= read_data_2_in;
  end

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      read_data_out  <= 16'd0;
      alu_result_out <= 16'd0;
      mux_rd_rt_out  <= 3'd0;
      MemToReg_out   <= 1'b0;
      RegWrite_out   <= 1'b0;
    end else begin
      read_data_out  <= (complete && MemRead_in && !fault)
                        ? mem[addr] : 16'd0;
      alu_result_out <= alu_result_in;
      mux_rd_rt_out  <= mux_rd_rt_in;
      MemToReg_out   <= MemToReg_in;
      RegWrite_out   <= RegWrite_in;
    end
  end

`ifdef MEM_RANGE_CHECK_EN
  logic fault_q;

  assign fault          = access & (|alu_result_in[15:ADDR_W]);
  assign addr_fault_out = fault_q;

  always_ff @(posedge clk) begin
    if (rst || bubble) fault_q <= 1'b0;
    else fault_q <= complete & fault;
  end
`else
  logic unused_hi;

  assign unused_hi      = ^alu_result_in[15:ADDR_W];
  assign fault          = 1'b0;
  assign addr_fault_out = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: one instance at latency 1, one at latency 3.
// Expected values are hand-computed; range-check results follow the macro.
module tb_mem_wb_stage;

  logic clk, rst;
  logic [15:0] alu[2], add[2], wd[2];
  logic [2:0]  rd[2];
  logic zero[2], m2r[2], rw[2], mr[2], mw[2], br[2];
  logic pc[2], st[2], m2rq[2], rwq[2], af[2];
  logic [15:0] bt[2], rdo[2], alo[2];
  logic [2:0]  rdq[2];

  int npass = 0;
  int ntotal = 0;

`ifdef MEM_RANGE_CHECK_EN
  localparam logic [15:0] EXP_AF = 16'd1;
  localparam logic [15:0] EXP5   = 16'h1111;
  localparam logic [15:0] EXP_HI = 16'h0000;
`else
  localparam logic [15:0] EXP_AF = 16'd0;
  localparam logic [15:0] EXP5   = 16'hAAAA;
  localparam logic [15:0] EXP_HI = 16'hAAAA;
`endif

  mem_wb_stage #(.ADDR_W(8), .MEM_LATENCY(1)) u0 (
    .clk(clk), .rst(rst),
    .alu_result_in(alu[0]), .zero_in(zero[0]),
    .adder_result_in(add[0]), .read_data_2_in(wd[0]),
    .mux_rd_rt_in(rd[0]), .MemToReg_in(m2r[0]),
    .RegWrite_in(rw[0]), .MemRead_in(mr[0]),
    .MemWrite_in(mw[0]), .Branch_in(br[0]),
    .pc_src(pc[0]), .branch_target(bt[0]),
    .mem_stall(st[0]), .read_data_out(rdo[0]),
    .alu_result_out(alo[0]), .mux_rd_rt_out(rdq[0]),
    .MemToReg_out(m2rq[0]), .RegWrite_out(rwq[0]),
    .addr_fault_out(af[0])
  );

  mem_wb_stage #(.ADDR_W(8), .MEM_LATENCY(3)) u1 (
    .clk(clk), .rst(rst),
    .alu_result_in(alu[1]), .zero_in(zero[1]),
    .adder_result_in(add[1]), .read_data_2_in(wd[1]),
    .mux_rd_rt_in(rd[1]), .MemToReg_in(m2r[1]),
    .RegWrite_in(rw[1]), .MemRead_in(mr[1]),
    .MemWrite_in(mw[1]), .Branch_in(br[1]),
    .pc_src(pc[1]), .branch_target(bt[1]),
    .mem_stall(st[1]), .read_data_out(rdo[1]),
    .alu_result_out(alo[1]), .mux_rd_rt_out(rdq[1]),
    .MemToReg_out(m2rq[1]), .RegWrite_out(rwq[1]),
    .addr_fault_out(af[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [15:0] a,
                       input logic [15:0] d, input logic [2:0] r,
                       input logic m2r_v, input logic rw_v,
                       input logic mr_v, input logic mw_v);
    alu[i]  = a;
    wd[i]   = d;
    rd[i]   = r;
    m2r[i]  = m2r_v;
    rw[i]   = rw_v;
    mr[i]   = mr_v;
    mw[i]   = mw_v;
    br[i]   = 1'b0;
    zero[i] = 1'b0;
    add[i]  = 16'd0;
    #1;
  endtask

  task automatic idle(input int i);
    drive(i, 16'd0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  initial begin
    // Reset with random inputs on both instances
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(i, 16'($urandom), 16'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    step();
    rst = 1'b0;
    idle(0);
    idle(1);
    for (int i = 0; i < 2; i++) begin
      chk("rst_rdo", rdo[i], 16'd0);
      chk("rst_alo", alo[i], 16'd0);
      chk("rst_rd", 16'(rdq[i]), 16'd0);
      chk("rst_m2r", 16'(m2rq[i]), 16'd0);
      chk("rst_rw", 16'(rwq[i]), 16'd0);
      chk("rst_af", 16'(af[i]), 16'd0);
      chk("rst_stall", 16'(st[i]), 16'd0);
    end

    // Latency 1: store then load
    drive(0, 16'd5, 16'hBEEF, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("l1_st_stall", 16'(st[0]), 16'd0);
    step();
    drive(0, 16'd5, 16'd0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("l1_ld_stall", 16'(st[0]), 16'd0);
    chk("l1_st_rw", 16'(rwq[0]), 16'd0);
    step();
    idle(0);
    chk("l1_ld_data", rdo[0], 16'hBEEF);
    chk("l1_ld_rd", 16'(rdq[0]), 16'd3);
    chk("l1_ld_rw", 16'(rwq[0]), 16'd1);
    chk("l1_ld_m2r", 16'(m2rq[0]), 16'd1);
    chk("l1_ld_alu", alo[0], 16'd5);

    // Read and write together: old contents returned
    drive(0, 16'd5, 16'h1111, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    idle(0);
    chk("rbw_old", rdo[0], 16'hBEEF);
    drive(0, 16'd5, 16'd0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    idle(0);
    chk("rbw_new", rdo[0], 16'h1111);

    // Reset wins over a completing store
    rst = 1'b1;
    drive(0, 16'd5, 16'h5555, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    rst = 1'b0;
    drive(0, 16'd5, 16'd0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    idle(0);
    chk("rst_prio", rdo[0], 16'h1111);

    // Branch resolve is combinational
    br[0] = 1'b1;
    zero[0] = 1'b1;
    add[0] = 16'h0040;
    #1;
    chk("br_taken", 16'(pc[0]), 16'd1);
    chk("br_target", bt[0], 16'h0040);
    zero[0] = 1'b0;
    #1;
    chk("br_not_taken", 16'(pc[0]), 16'd0);
    idle(0);

    // Latency 3: store then timed load
    drive(1, 16'd5, 16'hBEEF, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    step();
    step();
    idle(1);
    drive(1, 16'd5, 16'd0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("l3_stall_c0", 16'(st[1]), 16'd1);
    step();
    chk("l3_stall_c1", 16'(st[1]), 16'd1);
    chk("l3_bubble1", 16'(rwq[1]), 16'd0);
    step();
    chk("l3_stall_c2", 16'(st[1]), 16'd0);
    chk("l3_bubble2", 16'(rwq[1]), 16'd0);
    step();
    idle(1);
    chk("l3_ld_data", rdo[1], 16'hBEEF);
    chk("l3_ld_rw", 16'(rwq[1]), 16'd1);
    chk("l3_ld_rd", 16'(rdq[1]), 16'd3);
    chk("l3_stall_done", 16'(st[1]), 16'd0);

    // Latency 3: reset mid-access abandons the store
    drive(1, 16'd7, 16'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    step();
    step();
    idle(1);
    drive(1, 16'd7, 16'h1234, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("abort_stall0", 16'(st[1]), 16'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(1);
    chk("abort_stall", 16'(st[1]), 16'd0);
    chk("abort_rw", 16'(rwq[1]), 16'd0);
    step();
    drive(1, 16'd7, 16'd0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("abort_idle", 16'(st[1]), 16'd1);
    step();
    step();
    step();
    idle(1);
    chk("abort_mem", rdo[1], 16'h0000);

    // Upper address bits: fault or alias
    drive(0, 16'h0105, 16'hAAAA, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    idle(0);
    chk("hi_st_fault", 16'(af[0]), EXP_AF);
    step();
    chk("hi_fault_pulse", 16'(af[0]), 16'd0);
    drive(0, 16'd5, 16'd0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    idle(0);
    chk("hi_mem5", rdo[0], EXP5);
    chk("lo_ld_fault", 16'(af[0]), 16'd0);
    drive(0, 16'h0105, 16'd0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    idle(0);
    chk("hi_ld_data", rdo[0], EXP_HI);
    chk("hi_ld_fault", 16'(af[0]), EXP_AF);
    chk("hi_ld_rw", 16'(rwq[0]), 16'd1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
